// File: rtl/axi_single_master_pkg.sv
// Shared types and fixed AXI field values for axi_single_master.
// AXI width/response macros default here when no platform AXI_define.svh has set them.
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_RESP_OKAY
`define AXI_RESP_OKAY 2'b00
`endif
`ifndef AXI_RESP_DECERR
`define AXI_RESP_DECERR 2'b11
`endif

package axi_single_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RADDR,
    ST_RDATA,
    ST_WREQ,
    ST_WRESP
  } state_e;

  localparam logic [2:0]                 SIZE_WORD  = 3'b010;
  localparam logic [1:0]                 BURST_INCR = 2'b01;
  localparam logic [`AXI_LEN_BITS-1:0]   LEN_SINGLE = '0;

endpackage

// File: rtl/axi_single_master.sv
// One-outstanding request port to single-beat AXI4 read/write initiator.
// Optional ID/RLAST checking and sticky error output under AXI_SINGLE_MASTER_CHK_EN.
module axi_single_master
  import axi_single_master_pkg::*;
#(
  parameter logic [`AXI_ID_BITS-1:0] MASTER_ID = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [`AXI_ADDR_BITS-1:0]  req_addr,
  input  logic [`AXI_DATA_BITS-1:0]  req_wdata,
  input  logic [`AXI_STRB_BITS-1:0]  req_wstrb,
  output logic                       resp_valid,
  output logic [`AXI_DATA_BITS-1:0]  resp_rdata,
  output logic                       resp_err,
  output logic [`AXI_ID_BITS-1:0]    ARID,
  output logic [`AXI_ADDR_BITS-1:0]  ARADDR,
  output logic [`AXI_LEN_BITS-1:0]   ARLEN,
  output logic [2:0]                 ARSIZE,
  output logic [1:0]                 ARBURST,
  output logic                       ARVALID,
  input  logic                       ARREADY,
  input  logic [`AXI_ID_BITS-1:0]    RID,
  input  logic [`AXI_DATA_BITS-1:0]  RDATA,
  input  logic [1:0]                 RRESP,
  input  logic                       RLAST,
  input  logic                       RVALID,
  output logic                       RREADY,
  output logic [`AXI_ID_BITS-1:0]    AWID,
  output logic [`AXI_ADDR_BITS-1:0]  AWADDR,
  output logic [`AXI_LEN_BITS-1:0]   AWLEN,
  output logic [2:0]                 AWSIZE,
  output logic [1:0]                 AWBURST,
  output logic                       AWVALID,
  input  logic                       AWREADY,
  output logic [`AXI_DATA_BITS-1:0]  WDATA,
  output logic [`AXI_STRB_BITS-1:0]  WSTRB,
  output logic                       WLAST,
  output logic                       WVALID,
  input  logic                       WREADY,
  input  logic [`AXI_ID_BITS-1:0]    BID,
  input  logic [1:0]                 BRESP,
  input  logic                       BVALID,
  output logic                       BREADY
`ifdef AXI_SINGLE_MASTER_CHK_EN
  ,
  output logic                       err_sticky
`endif
);

  state_e                      state_q, state_d;
  logic [`AXI_ADDR_BITS-1:0]   addr_q, addr_d;
  logic [`AXI_DATA_BITS-1:0]   wdata_q, wdata_d;
  logic [`AXI_STRB_BITS-1:0]   wstrb_q, wstrb_d;
  logic                        aw_done_q, aw_done_d;
  logic                        w_done_q, w_done_d;
  logic                        resp_valid_q, resp_valid_d;
  logic [`AXI_DATA_BITS-1:0]   resp_rdata_q, resp_rdata_d;
  logic                        resp_err_q, resp_err_d;
  logic                        rd_chk_err;
  logic                        wr_chk_err;

`ifdef AXI_SINGLE_MASTER_CHK_EN
  logic err_sticky_q, err_sticky_d;

  assign rd_chk_err = (RID != MASTER_ID) || !RLAST;
  assign wr_chk_err = (BID != MASTER_ID);
  assign err_sticky_d = err_sticky_q | (resp_valid_d & resp_err_d);
  assign err_sticky = err_sticky_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_sticky_q <= 1'b0;
    else      err_sticky_q <= err_sticky_d;
  end
`else
  logic unused_chk;

  assign rd_chk_err = 1'b0;
  assign wr_chk_err = 1'b0;
  assign unused_chk = ^{RID, BID, RLAST};
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    req_ready    = 1'b0;
    ARVALID      = 1'b0;
    RREADY       = 1'b0;
    AWVALID      = 1'b0;
    WVALID       = 1'b0;
    BREADY       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          state_d = req_we ? ST_WREQ : ST_RADDR;
        end
      end
      ST_RADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        RREADY = 1'b1;
        if (RVALID) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = RDATA;
          resp_err_d   = (RRESP != `AXI_RESP_OKAY) || rd_chk_err;
          state_d      = ST_IDLE;
        end
      end
      ST_WREQ: begin
        // AW and W run independently; leave once both have handshaken.
        AWVALID = !aw_done_q;
        WVALID  = !w_done_q;
        if (AWVALID && AWREADY) aw_done_d = 1'b1;
        if (WVALID && WREADY)   w_done_d  = 1'b1;
        if ((aw_done_q || AWREADY) && (w_done_q || WREADY)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_WRESP;
        end
      end
      ST_WRESP: begin
        BREADY = 1'b1;
        if (BVALID) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          resp_err_d   = (BRESP != `AXI_RESP_OKAY) || wr_chk_err;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  assign ARID    = MASTER_ID;
  assign ARADDR  = addr_q;
  assign ARLEN   = LEN_SINGLE;
  assign ARSIZE  = SIZE_WORD;
  assign ARBURST = BURST_INCR;

  assign AWID    = MASTER_ID;
  assign AWADDR  = addr_q;
  assign AWLEN   = LEN_SINGLE;
  assign AWSIZE  = SIZE_WORD;
  assign AWBURST = BURST_INCR;

  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;
  assign WLAST   = 1'b1;

endmodule

// File: tb/tb_axi_single_master.sv
// Directed bench for axi_single_master: the bench plays the AXI slave with scripted ready/valid timing.
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif

module tb_axi_single_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                       req_valid, req_ready, req_we;
  logic [`AXI_ADDR_BITS-1:0]  req_addr;
  logic [`AXI_DATA_BITS-1:0]  req_wdata;
  logic [`AXI_STRB_BITS-1:0]  req_wstrb;
  logic                       resp_valid, resp_err;
  logic [`AXI_DATA_BITS-1:0]  resp_rdata;
  logic [`AXI_ID_BITS-1:0]    ARID, AWID, RID, BID;
  logic [`AXI_ADDR_BITS-1:0]  ARADDR, AWADDR;
  logic [`AXI_LEN_BITS-1:0]   ARLEN, AWLEN;
  logic [2:0]                 ARSIZE, AWSIZE;
  logic [1:0]                 ARBURST, AWBURST, RRESP, BRESP;
  logic                       ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic                       AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic [`AXI_DATA_BITS-1:0]  RDATA, WDATA;
  logic [`AXI_STRB_BITS-1:0]  WSTRB;
`ifdef AXI_SINGLE_MASTER_CHK_EN
  logic                       err_sticky;
`endif

  int passed = 0;
  int total  = 0;
  int ar_hs = 0, aw_hs = 0, w_hs = 0, resp_cnt = 0;

  axi_single_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
`ifdef AXI_SINGLE_MASTER_CHK_EN
    , .err_sticky(err_sticky)
`endif
  );

  always @(posedge clk) begin
    if (ARVALID && ARREADY) ar_hs <= ar_hs + 1;
    if (AWVALID && AWREADY) aw_hs <= aw_hs + 1;
    if (WVALID && WREADY)   w_hs  <= w_hs + 1;
    if (resp_valid)         resp_cnt <= resp_cnt + 1;
  end

  task automatic drive_req(input logic v, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
  endtask

  task automatic set_slave(input logic arr, input logic rv, input logic [31:0] rd,
                           input logic [1:0] rr, input logic awr, input logic wr,
                           input logic bv, input logic [1:0] br);
    ARREADY = arr; RVALID = rv; RDATA = rd; RRESP = rr;
    AWREADY = awr; WREADY = wr; BVALID = bv; BRESP = br;
  endtask

  task automatic test_reset();
    drive_req(0, 0, 0, 0, 0);
    set_slave(0, 0, 0, 2'b00, 0, 0, 0, 2'b00);
    RID = '0; BID = '0; RLAST = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({ARVALID, AWVALID, WVALID, RREADY, BREADY} !== 5'b0)
      $display("FAIL reset_handshake_outs: got %b want 00000", {ARVALID, AWVALID, WVALID, RREADY, BREADY}); else passed++;
    total++; if ({resp_valid, resp_err, resp_rdata} !== 34'h0)
      $display("FAIL reset_resp: got v=%b e=%b d=%h want all 0", resp_valid, resp_err, resp_rdata); else passed++;
`ifdef AXI_SINGLE_MASTER_CHK_EN
    total++; if (err_sticky !== 1'b0) $display("FAIL reset_sticky: got %b want 0", err_sticky); else passed++;
`endif
    rst = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else passed++;
  endtask

  task automatic test_read_basic();
    int r0;
    r0 = resp_cnt;
    set_slave(1, 1, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 2'b00);
    drive_req(1, 0, 32'h0000_0100, 0, 0);
    @(negedge clk); // cycle 1
    drive_req(0, 0, 0, 0, 0);
    total++; if (ARVALID !== 1'b1 || ARADDR !== 32'h0000_0100)
      $display("FAIL rd_ar_c1: got v=%b a=%h want 1 00000100", ARVALID, ARADDR); else passed++;
    total++; if ({ARID, ARLEN, ARSIZE, ARBURST} !== {4'd0, 8'd0, 3'b010, 2'b01})
      $display("FAIL rd_ar_fixed: got id=%h len=%h size=%b burst=%b", ARID, ARLEN, ARSIZE, ARBURST); else passed++;
    total++; if (req_ready !== 1'b0) $display("FAIL rd_req_ready_busy: got %b want 0", req_ready); else passed++;
    @(negedge clk); // cycle 2
    total++; if (RREADY !== 1'b1 || ARVALID !== 1'b0 || resp_valid !== 1'b0)
      $display("FAIL rd_r_c2: got rready=%b arvalid=%b resp_valid=%b want 1 0 0", RREADY, ARVALID, resp_valid); else passed++;
    @(negedge clk); // cycle 3
    total++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD_BEEF || resp_err !== 1'b0)
      $display("FAIL rd_resp_c3: got v=%b d=%h e=%b want 1 deadbeef 0", resp_valid, resp_rdata, resp_err); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL rd_req_ready_resp: got %b want 1", req_ready); else passed++;
    set_slave(0, 0, 0, 2'b00, 0, 0, 0, 2'b00);
    @(negedge clk);
    total++; if (resp_valid !== 1'b0 || resp_cnt - r0 != 1)
      $display("FAIL rd_resp_pulse: got v=%b count=%0d want 0 1", resp_valid, resp_cnt - r0); else passed++;
  endtask

  task automatic test_write_w_first();
    int r0, aw0, w0;
    r0 = resp_cnt; aw0 = aw_hs; w0 = w_hs;
    set_slave(0, 0, 0, 2'b00, 0, 0, 0, 2'b00);
    drive_req(1, 1, 32'h0000_0300, 32'h0000_0010, 4'hF);
    @(negedge clk); // cycle 1
    drive_req(0, 0, 0, 0, 0);
    total++; if ({AWVALID, WVALID, WLAST} !== 3'b111)
      $display("FAIL wr_valids_c1: got aw=%b w=%b last=%b want 1 1 1", AWVALID, WVALID, WLAST); else passed++;
    total++; if (AWADDR !== 32'h0000_0300 || WDATA !== 32'h0000_0010 || WSTRB !== 4'hF)
      $display("FAIL wr_payload: got a=%h d=%h s=%h want 00000300 00000010 f", AWADDR, WDATA, WSTRB); else passed++;
    WREADY = 1'b1;
    @(negedge clk); // cycle 2
    WREADY = 1'b0;
    total++; if (AWVALID !== 1'b1 || WVALID !== 1'b0)
      $display("FAIL wr_after_w: got aw=%b w=%b want 1 0", AWVALID, WVALID); else passed++;
    @(negedge clk); // cycle 3
    total++; if (AWVALID !== 1'b1 || WVALID !== 1'b0 || AWADDR !== 32'h0000_0300)
      $display("FAIL wr_aw_hold: got aw=%b w=%b a=%h want 1 0 00000300", AWVALID, WVALID, AWADDR); else passed++;
    AWREADY = 1'b1;
    @(negedge clk); // cycle 4
    AWREADY = 1'b0;
    total++; if (AWVALID !== 1'b0 || BREADY !== 1'b1)
      $display("FAIL wr_bready: got aw=%b bready=%b want 0 1", AWVALID, BREADY); else passed++;
    BVALID = 1'b1; BRESP = 2'b00;
    @(negedge clk); // cycle 5
    BVALID = 1'b0;
    total++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0)
      $display("FAIL wr_resp: got v=%b e=%b d=%h want 1 0 00000000", resp_valid, resp_err, resp_rdata); else passed++;
    @(negedge clk);
    total++; if (aw_hs - aw0 != 1 || w_hs - w0 != 1 || resp_cnt - r0 != 1)
      $display("FAIL wr_beat_counts: got aw=%0d w=%0d resp=%0d want 1 1 1", aw_hs - aw0, w_hs - w0, resp_cnt - r0); else passed++;
  endtask

  task automatic test_read_decerr();
    set_slave(1, 1, 32'h1234_5678, 2'b11, 0, 0, 0, 2'b00);
    drive_req(1, 0, 32'h0000_0200, 0, 0);
    @(negedge clk);
    drive_req(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk); // cycle 3
    total++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h1234_5678)
      $display("FAIL decerr_resp: got v=%b e=%b d=%h want 1 1 12345678", resp_valid, resp_err, resp_rdata); else passed++;
    set_slave(0, 0, 0, 2'b00, 0, 0, 0, 2'b00);
    @(negedge clk);
`ifdef AXI_SINGLE_MASTER_CHK_EN
    total++; if (err_sticky !== 1'b1) $display("FAIL decerr_sticky: got %b want 1", err_sticky); else passed++;
`endif
  endtask

  task automatic test_arready_stall();
    int a0;
    a0 = ar_hs;
    set_slave(0, 0, 0, 2'b00, 0, 0, 0, 2'b00);
    drive_req(1, 0, 32'h0000_0A40, 0, 0);
    @(negedge clk); // cycle 1
    drive_req(1, 1, 32'h0000_0BB0, 32'hFFFF_FFFF, 4'h3);
    for (int i = 0; i < 5; i++) begin
      total++; if (ARVALID !== 1'b1 || ARADDR !== 32'h0000_0A40 || req_ready !== 1'b0)
        $display("FAIL stall_hold_%0d: got v=%b a=%h rdy=%b want 1 00000a40 0", i, ARVALID, ARADDR, req_ready); else passed++;
      @(negedge clk);
    end
    // cycle 6
    drive_req(0, 0, 0, 0, 0);
    ARREADY = 1'b1;
    @(negedge clk); // cycle 7
    set_slave(0, 1, 32'h5555_AAAA, 2'b00, 0, 0, 0, 2'b00);
    @(negedge clk); // cycle 8
    set_slave(0, 0, 0, 2'b00, 0, 0, 0, 2'b00);
    total++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h5555_AAAA || resp_err !== 1'b0 || ar_hs - a0 != 1)
      $display("FAIL stall_resp: got v=%b d=%h e=%b ar=%0d want 1 5555aaaa 0 1", resp_valid, resp_rdata, resp_err, ar_hs - a0); else passed++;
`ifdef AXI_SINGLE_MASTER_CHK_EN
    total++; if (err_sticky !== 1'b1) $display("FAIL sticky_holds: got %b want 1", err_sticky); else passed++;
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_in_wreq();
    int r0;
    set_slave(0, 0, 0, 2'b00, 0, 0, 0, 2'b00);
    drive_req(1, 1, 32'h0000_0400, 32'hA5A5_A5A5, 4'hF);
    @(negedge clk); // cycle 1
    drive_req(0, 0, 0, 0, 0);
    total++; if (AWVALID !== 1'b1 || WVALID !== 1'b1)
      $display("FAIL rstw_pre: got aw=%b w=%b want 1 1", AWVALID, WVALID); else passed++;
    r0 = resp_cnt;
    #2 rst = 1'b0;
    #1;
    total++; if (AWVALID !== 1'b0 || WVALID !== 1'b0)
      $display("FAIL rstw_async_drop: got aw=%b w=%b want 0 0", AWVALID, WVALID); else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (resp_cnt != r0 || AWVALID !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL rstw_no_resp: got resp=%0d aw=%b rdy=%b want 0 0 1", resp_cnt - r0, AWVALID, req_ready); else passed++;
    set_slave(1, 1, 32'h0F0F_1234, 2'b00, 0, 0, 0, 2'b00);
    drive_req(1, 0, 32'h0000_0500, 0, 0);
    @(negedge clk);
    drive_req(0, 0, 0, 0, 0);
    total++; if (ARADDR !== 32'h0000_0500 || ARVALID !== 1'b1)
      $display("FAIL rstw_read_ar: got v=%b a=%h want 1 00000500", ARVALID, ARADDR); else passed++;
    repeat (2) @(negedge clk);
    set_slave(0, 0, 0, 2'b00, 0, 0, 0, 2'b00);
    total++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0F0F_1234 || resp_err !== 1'b0)
      $display("FAIL rstw_read_resp: got v=%b d=%h e=%b want 1 0f0f1234 0", resp_valid, resp_rdata, resp_err); else passed++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    set_slave(1, 1, 32'h0BAD_F00D, 2'b00, 1, 1, 1, 2'b00);
    drive_req(1, 1, 32'h0000_0040, 32'h0000_CAFE, 4'hF);
    @(negedge clk); // cycle 1
    total++; if (AWVALID !== 1'b1 || WVALID !== 1'b1 || WDATA !== 32'h0000_CAFE)
      $display("FAIL b2b_aw_w: got aw=%b w=%b d=%h want 1 1 0000cafe", AWVALID, WVALID, WDATA); else passed++;
    @(negedge clk); // cycle 2
    total++; if (BREADY !== 1'b1 || req_ready !== 1'b0)
      $display("FAIL b2b_b: got bready=%b rdy=%b want 1 0", BREADY, req_ready); else passed++;
    @(negedge clk); // cycle 3
    total++; if (resp_valid !== 1'b1 || req_ready !== 1'b1 || resp_rdata !== 32'h0)
      $display("FAIL b2b_overlap: got v=%b rdy=%b d=%h want 1 1 00000000", resp_valid, req_ready, resp_rdata); else passed++;
    drive_req(1, 0, 32'h0000_0080, 0, 0);
    @(negedge clk); // cycle 4
    drive_req(0, 0, 0, 0, 0);
    total++; if (ARVALID !== 1'b1 || ARADDR !== 32'h0000_0080 || resp_valid !== 1'b0)
      $display("FAIL b2b_second_ar: got v=%b a=%h rv=%b want 1 00000080 0", ARVALID, ARADDR, resp_valid); else passed++;
    repeat (2) @(negedge clk); // cycle 6
    set_slave(0, 0, 0, 2'b00, 0, 0, 0, 2'b00);
    total++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0BAD_F00D || resp_err !== 1'b0)
      $display("FAIL b2b_second_resp: got v=%b d=%h e=%b want 1 0badf00d 0", resp_valid, resp_rdata, resp_err); else passed++;
    @(negedge clk);
  endtask

`ifdef AXI_SINGLE_MASTER_CHK_EN
  task automatic test_chk_rlast();
    set_slave(1, 1, 32'h0000_0077, 2'b00, 0, 0, 0, 2'b00);
    RLAST = 1'b0;
    drive_req(1, 0, 32'h0000_0600, 0, 0);
    @(negedge clk);
    drive_req(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    set_slave(0, 0, 0, 2'b00, 0, 0, 0, 2'b00);
    RLAST = 1'b1;
    total++; if (resp_valid !== 1'b1 || resp_err !== 1'b1)
      $display("FAIL chk_rlast: got v=%b e=%b want 1 1", resp_valid, resp_err); else passed++;
    @(negedge clk);
    total++; if (err_sticky !== 1'b1) $display("FAIL chk_sticky: got %b want 1", err_sticky); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_read_basic();
    test_write_w_first();
    test_read_decerr();
    test_arready_stall();
    test_reset_in_wreq();
    test_back_to_back();
`ifdef AXI_SINGLE_MASTER_CHK_EN
    test_chk_rlast();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
